module_controle: RTL and testbench

- Instruction sequencer that sits in front of the ALU (module_alu).
- Accepts one 18-bit instruction per valid/ready handshake and decodes it into the ALU's opcode/sinalImm/Imm fields.
- Reads operands from an internal 16x16 register bank, drives v1ULA/v2ULA, and writes valorGuardarULA back to the bank.
- Handles CLEAR and DISPLAY locally; it is the issuing and write-back end of the ALU interface.

---
 rtl/module_controle_if.sv | 28 ++
 rtl/module_controle.sv | 121 ++++++++++++
 tb/tb_module_controle.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/module_controle_if.sv
// Instruction/ALU bundle between the sequencer and its environment.
// The slave side is the sequencer; the master side issues instructions and returns ALU results.
interface module_controle_if;
    logic [17:0] instr;
    logic        instrValid;
    logic        instrReady;
    logic [2:0]  opcode;
    logic        sinalImm;
    logic [5:0]  Imm;
    logic [15:0] v1ULA;
    logic [15:0] v2ULA;
    logic [15:0] valorGuardarULA;
    logic [15:0] displayValor;
    logic        displayValid;
    logic        done;

    modport master (
        output instr, instrValid, valorGuardarULA,
        input  instrReady, opcode, sinalImm, Imm, v1ULA, v2ULA,
        input  displayValor, displayValid, done
    );

    modport slave (
        input  instr, instrValid, valorGuardarULA,
        output instrReady, opcode, sinalImm, Imm, v1ULA, v2ULA,
        output displayValor, displayValid, done
    );
endinterface

// File: rtl/module_controle.sv
// Instruction sequencer in front of the ALU: decodes, reads the 16x16 bank,
// waits ALU_LAT cycles, writes back; CLEAR and DISPLAY are handled locally.
module module_controle #(
    parameter int ALU_LAT = 1,
    parameter int NREG    = 16
) (
    input logic               clk,
    input logic               rst,
    module_controle_if.slave  ctrl_bus
);
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;
    localparam logic [2:0] LAT        = 3'(ALU_LAT);

    typedef enum logic [2:0] {IDLE, EXEC, WB, CLR, DISP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [2:0]  op_q;
    logic        sinal_q;
    logic [5:0]  imm_q;
    logic [3:0]  dest_q;
    logic [15:0] v1_q, v2_q, disp_q;
    logic        done_q;
    logic [15:0] regs_q [NREG];

    logic [2:0] in_op;
    logic [3:0] in_dest, in_src1, in_src2;
    logic       accept;

    assign in_op   = ctrl_bus.instr[17:15];
    assign in_dest = ctrl_bus.instr[14:11];
    assign in_src1 = ctrl_bus.instr[10:7];
    assign in_src2 = ctrl_bus.instr[6:3];
    assign accept  = (state_q == IDLE) && ctrl_bus.instrValid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_op == OP_CLEAR)        state_d = CLR;
                    else if (in_op == OP_DISPLAY) state_d = DISP;
                    else                          state_d = EXEC;
                end
            end
            EXEC:    if (cnt_q == LAT) state_d = WB;
            WB:      state_d = IDLE;
            CLR:     state_d = IDLE;
            DISP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode fields and operands are captured at accept and held for the ALU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            op_q    <= '0;
            sinal_q <= 1'b0;
            imm_q   <= '0;
            dest_q  <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            disp_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == WB) || (state_q == CLR);
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= in_op;
                        sinal_q <= ctrl_bus.instr[6];
                        imm_q   <= ctrl_bus.instr[5:0];
                        dest_q  <= in_dest;
                        cnt_q   <= '0;
                        if (in_op <= OP_MUL) begin
                            v1_q <= regs_q[in_src1];
                            v2_q <= regs_q[in_src2];
                        end
                        if (in_op == OP_DISPLAY) disp_q <= regs_q[in_dest];
                    end
                end
                EXEC:    cnt_q <= cnt_q + 3'd1;
                default: ;
            endcase
        end
    end

    // Register bank: operands above are read before this write lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (state_q == CLR) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (state_q == WB) begin
            regs_q[dest_q] <= ctrl_bus.valorGuardarULA;
        end
    end

    // Output logic
    always_comb begin
        ctrl_bus.instrReady   = (state_q == IDLE);
        ctrl_bus.displayValid = (state_q == DISP);
        ctrl_bus.done         = done_q || (state_q == DISP);
        ctrl_bus.opcode       = op_q;
        ctrl_bus.sinalImm     = sinal_q;
        ctrl_bus.Imm          = imm_q;
        ctrl_bus.v1ULA        = v1_q;
        ctrl_bus.v2ULA        = v2_q;
        ctrl_bus.displayValor = disp_q;
    end
endmodule

// File: tb/tb_module_controle.sv
// Directed bench for module_controle with an ALU model; DISPLAY results are scoreboarded.
module tb_module_controle;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] instr_r = '0;
    logic        valid_r = 1'b0;
    logic        sel = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] model [16];
    logic [15:0] exp_q [$];
    logic [15:0] cur_e1, cur_e2;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu(input logic [2:0] op, input logic s, input logic [5:0] imm,
                                        input logic [15:0] a, input logic [15:0] b);
        logic [15:0] iv;
        iv = s ? (16'd0 - {10'd0, imm}) : {10'd0, imm};
        case (op)
            3'd0:    return iv;
            3'd1:    return a + b;
            3'd2:    return a + iv;
            3'd3:    return a - b;
            3'd4:    return a - iv;
            3'd5:    return a * b;
            default: return 16'd0;
        endcase
    endfunction

    module_controle_if bus1();
    module_controle_if bus3();

    assign bus1.instr           = instr_r;
    assign bus1.instrValid      = valid_r && !sel;
    assign bus1.valorGuardarULA = alu(bus1.opcode, bus1.sinalImm, bus1.Imm, bus1.v1ULA, bus1.v2ULA);
    assign bus3.instr           = instr_r;
    assign bus3.instrValid      = valid_r && sel;
    assign bus3.valorGuardarULA = alu(bus3.opcode, bus3.sinalImm, bus3.Imm, bus3.v1ULA, bus3.v2ULA);

    module_controle #(.ALU_LAT(1), .NREG(16)) dut1 (.clk(clk), .rst(rst), .ctrl_bus(bus1));
    module_controle #(.ALU_LAT(3), .NREG(16)) dut3 (.clk(clk), .rst(rst), .ctrl_bus(bus3));

    logic        m_ready, m_done, m_dv, m_sinal;
    logic [2:0]  m_op;
    logic [5:0]  m_imm;
    logic [15:0] m_v1, m_v2, m_disp;

    always_comb begin
        m_ready = sel ? bus3.instrReady   : bus1.instrReady;
        m_done  = sel ? bus3.done         : bus1.done;
        m_dv    = sel ? bus3.displayValid : bus1.displayValid;
        m_sinal = sel ? bus3.sinalImm     : bus1.sinalImm;
        m_op    = sel ? bus3.opcode       : bus1.opcode;
        m_imm   = sel ? bus3.Imm          : bus1.Imm;
        m_v1    = sel ? bus3.v1ULA        : bus1.v1ULA;
        m_v2    = sel ? bus3.v2ULA        : bus1.v2ULA;
        m_disp  = sel ? bus3.displayValor : bus1.displayValor;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every displayValid pulse pops one expected value
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst && m_dv) begin
            if (exp_q.size() == 0) begin
                check("disp_unexpected", 32'(m_disp), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("disp_val", 32'(m_disp), 32'(e));
            end
        end
    end

    function automatic logic [17:0] mk(input logic [2:0] op, input logic [3:0] d,
                                       input logic [3:0] s1, input logic [3:0] s2);
        return {op, d, s1, s2, 3'b000};
    endfunction

    function automatic logic [17:0] mki(input logic [2:0] op, input logic [3:0] d,
                                        input logic [3:0] s1, input logic s, input logic [5:0] imm);
        return {op, d, s1, s, imm};
    endfunction

    task automatic predict(input logic [17:0] ins);
        logic [2:0] op;
        logic [3:0] d;
        op = ins[17:15];
        d  = ins[14:11];
        cur_e1 = model[ins[10:7]];
        cur_e2 = model[ins[6:3]];
        if (op <= 3'd5) model[d] = alu(op, ins[6], ins[5:0], cur_e1, cur_e2);
        else if (op == 3'd6) for (int i = 0; i < 16; i++) model[i] = 16'd0;
        else exp_q.push_back(model[d]);
    endtask

    task automatic send(input logic [17:0] ins);
        int n = 0;
        while (!m_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(m_ready), 32'd1);
        predict(ins);
        instr_r = ins;
        valid_r = 1'b1;
        @(posedge clk);
        #1 valid_r = 1'b0;
    endtask

    task automatic track(input logic [17:0] ins, input bit hold_next);
        logic [2:0] op;
        int lat, exp_k, k, low;
        bit seen;
        op    = ins[17:15];
        lat   = sel ? 3 : 1;
        exp_k = (op == 3'd6) ? 1 : (op == 3'd7) ? 0 : lat + 2;
        low   = 0;
        seen  = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (op <= 3'd5 && k <= lat) begin
                check("exec_v1", 32'(m_v1), 32'(cur_e1));
                check("exec_v2", 32'(m_v2), 32'(cur_e2));
                check("exec_op", 32'(m_op), 32'(op));
            end
            if (m_done) begin
                seen = 1'b1;
                break;
            end
            if (!m_ready) low++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_edges", 32'(k), 32'(exp_k));
        if (op != 3'd7) check("ready_gap", 32'(low), 32'(exp_k));
        if (!hold_next) begin
            @(negedge clk);
            check("done_single", 32'(m_done), 32'd0);
        end
    endtask

    task automatic run(input logic [17:0] ins);
        send(ins);
        track(ins, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op"},    32'(m_op), 32'd0);
        check({tag, "_sinal"}, 32'(m_sinal), 32'd0);
        check({tag, "_imm"},   32'(m_imm), 32'd0);
        check({tag, "_v1"},    32'(m_v1), 32'd0);
        check({tag, "_v2"},    32'(m_v2), 32'd0);
        check({tag, "_disp"},  32'(m_disp), 32'd0);
        check({tag, "_dv"},    32'(m_dv), 32'd0);
        check({tag, "_done"},  32'(m_done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 16'd0;
        cur_e1 = 16'd0;
        cur_e2 = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(m_ready), 32'd1);

        // LOAD and readback
        run(mki(3'd0, 4'd3, 4'd0, 1'b0, 6'd25));
        run(mk(3'd7, 4'd3, 4'd0, 4'd0));

        // ADD / SUB with DISPLAY
        run(mki(3'd0, 4'd1, 4'd0, 1'b0, 6'd10));
        run(mki(3'd0, 4'd2, 4'd0, 1'b0, 6'd7));
        run(mk(3'd1, 4'd4, 4'd1, 4'd2));
        run(mk(3'd7, 4'd4, 4'd0, 4'd0));
        run(mk(3'd3, 4'd5, 4'd1, 4'd2));
        run(mk(3'd7, 4'd5, 4'd0, 4'd0));

        // dest aliases sources; a second instruction is held valid while busy
        run(mki(3'd0, 4'd1, 4'd0, 1'b0, 6'd9));
        send(mk(3'd1, 4'd1, 4'd1, 4'd1));
        instr_r = mki(3'd0, 4'd7, 4'd0, 1'b0, 6'd33);
        valid_r = 1'b1;
        track(mk(3'd1, 4'd1, 4'd1, 4'd1), 1'b1);
        predict(instr_r);
        @(posedge clk);
        #1 valid_r = 1'b0;
        track(mki(3'd0, 4'd7, 4'd0, 1'b0, 6'd33), 1'b0);
        run(mk(3'd7, 4'd1, 4'd0, 4'd0));
        run(mk(3'd7, 4'd7, 4'd0, 4'd0));

        // Fill bank, MUL and negative SUBI, then CLEAR
        for (int i = 0; i < 16; i++) run(mki(3'd0, 4'(i), 4'd0, 1'b0, 6'(i + 1)));
        run(mk(3'd5, 4'd0, 4'd14, 4'd15));
        run(mk(3'd7, 4'd0, 4'd0, 4'd0));
        run(mki(3'd4, 4'd1, 4'd1, 1'b1, 6'd3));
        run(mk(3'd7, 4'd1, 4'd0, 4'd0));
        run(mk(3'd6, 4'd0, 4'd0, 4'd0));
        for (int i = 0; i < 16; i++) run(mk(3'd7, 4'(i), 4'd0, 4'd0));

        // Reset during EXEC aborts the write
        run(mki(3'd0, 4'd1, 4'd0, 1'b0, 6'd11));
        run(mki(3'd0, 4'd2, 4'd0, 1'b0, 6'd12));
        instr_r = mk(3'd1, 4'd6, 4'd1, 4'd2);
        valid_r = 1'b1;
        @(posedge clk);
        #1 valid_r = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 16'd0;
        exp_q.delete();
        #1;
        check("ready_post_rst", 32'(m_ready), 32'd1);
        run(mk(3'd7, 4'd6, 4'd0, 4'd0));
        run(mk(3'd7, 4'd1, 4'd0, 4'd0));

        // Longer ALU latency instance
        sel = 1'b1;
        @(negedge clk);
        run(mki(3'd0, 4'd1, 4'd0, 1'b0, 6'd50));
        run(mki(3'd1, 4'd1, 4'd1, 1'b0, 6'd8));
        run(mk(3'd1, 4'd1, 4'd1, 4'd1));
        run(mki(3'd2, 4'd2, 4'd1, 1'b0, 6'd5));
        run(mk(3'd7, 4'd2, 4'd0, 4'd0));
        run(mk(3'd5, 4'd3, 4'd2, 4'd2));
        run(mk(3'd7, 4'd3, 4'd0, 4'd0));
        run(mki(3'd4, 4'd4, 4'd2, 1'b0, 6'd40));
        run(mk(3'd7, 4'd4, 4'd0, 4'd0));

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
